// File: rtl/dram_feature_pkg.sv
// Shared types and constants for the feature-map DRAM read address generator.
// Holds the controller state encoding, the AXI beat geometry helpers and the 4 KB page constant.
package dram_feature_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    NEXT  = 2'd3
  } frd_state_e;

  localparam int AXI_LEN_W     = 8;
  localparam int BOUNDARY_4K   = 4096;
  localparam int BOUNDARY_4K_W = 13;

  function automatic int beat_bytes(input int axiwidth);
    return axiwidth / 8;
  endfunction

  function automatic int beat_shift(input int axiwidth);
    return $clog2(axiwidth / 8);
  endfunction

endpackage

// File: rtl/dram_burst_splitter.sv
// Turns a start address plus beat count into a valid/ready sequence of AXI bursts.
// With DRAM_FRD_4K_SPLIT_EN defined, bursts additionally stop at every 4 KB page boundary.
module dram_burst_splitter
  import dram_feature_pkg::*;
#(
  parameter int LITEWIDTH = 32,
  parameter int AXIWIDTH  = 128,
  parameter int BEATS_W   = 19,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LITEWIDTH-1:0] start_addr,
  input  logic [BEATS_W-1:0]   start_beats,
  output logic                 rd_valid,
  output logic [LITEWIDTH-1:0] rd_addr,
  output logic [AXI_LEN_W-1:0] rd_len,
  input  logic                 rd_ready,
  output logic                 last_hs
);

  localparam int SHIFT = beat_shift(AXIWIDTH);
  localparam logic [BEATS_W-1:0] MAX_B = BEATS_W'(MAX_BURST);

  logic [LITEWIDTH-1:0] addr_reg;
  logic [BEATS_W-1:0]   rem_reg;
  logic                 valid_reg;
  logic [BEATS_W-1:0]   cap_beats;
  logic [BEATS_W-1:0]   beats;
  logic                 hs;

  always_comb begin
    cap_beats = (rem_reg < MAX_B) ? rem_reg : MAX_B;
  end

`ifdef DRAM_FRD_4K_SPLIT_EN
  logic [BOUNDARY_4K_W-1:0] bnd_bytes;
  logic [BOUNDARY_4K_W-1:0] bnd_beats;

  // cap_beats never exceeds 256, so the comparison fits in the 13-bit page domain
  always_comb begin
    bnd_bytes = BOUNDARY_4K_W'(BOUNDARY_4K) - {1'b0, addr_reg[11:0]};
    bnd_beats = bnd_bytes >> SHIFT;
    if (bnd_beats == '0) begin
      bnd_beats = BOUNDARY_4K_W'(1);
    end
    if (bnd_beats < BOUNDARY_4K_W'(cap_beats)) begin
      beats = BEATS_W'(bnd_beats);
    end else begin
      beats = cap_beats;
    end
  end
`else
  always_comb begin
    beats = cap_beats;
  end
`endif

  always_comb begin
    hs      = valid_reg & rd_ready;
    last_hs = hs & (rem_reg == beats);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      rem_reg   <= '0;
    end else if (start) begin
      valid_reg <= (start_beats != '0);
      addr_reg  <= start_addr;
      rem_reg   <= start_beats;
    end else if (hs) begin
      addr_reg  <= addr_reg + (LITEWIDTH'(beats) << SHIFT);
      rem_reg   <= rem_reg - beats;
      valid_reg <= (rem_reg != beats);
    end
  end

  assign rd_valid = valid_reg;
  assign rd_addr  = addr_reg;
  assign rd_len   = AXI_LEN_W'(beats - 1'b1);

endmodule

// File: rtl/dram_feature_rd_addr_gen.sv
// Feature-map read address generator: walks the rows of a request, skips padding rows and
// hands each real row to the burst splitter. Optional 4 KB split via DRAM_FRD_4K_SPLIT_EN.
module dram_feature_rd_addr_gen
  import dram_feature_pkg::*;
#(
  parameter int W_WIDTH      = 10,
  parameter int LITEWIDTH    = 32,
  parameter int DEPTHWIDTH   = 9,
  parameter int AXIWIDTH     = 128,
  parameter int ROWS_PER_REQ = 3,
  parameter int MAX_BURST    = 16
) (
  input  logic                              I_clk,
  input  logic                              I_rst_n,
  input  logic                              I_ap_start,
  input  logic                              I_compute_en,
  input  logic [LITEWIDTH-1:0]              I_feature_base_addr,
  input  logic [DEPTHWIDTH-1:0]             I_ciMemGroup,
  input  logic [W_WIDTH-1:0]                I_iheight,
  input  logic [W_WIDTH-1:0]                I_iwidth,
  input  logic                              I_row_req,
  input  logic [W_WIDTH-1:0]                I_hindex,
  input  logic [$clog2(ROWS_PER_REQ+1)-1:0] I_row_cnt,
  output logic                              O_req_rdy,
  output logic [LITEWIDTH-1:0]              O_rd_addr,
  output logic [AXI_LEN_W-1:0]              O_rd_len,
  output logic                              O_rd_valid,
  input  logic                              I_rd_ready,
  output logic                              O_row_done,
  output logic                              O_pad_row,
  output logic                              O_req_done,
  output logic                              O_err
);

  localparam int CNT_W = $clog2(ROWS_PER_REQ + 1);
  localparam int LB_W  = DEPTHWIDTH + W_WIDTH;
  localparam int SHIFT = beat_shift(AXIWIDTH);

  frd_state_e state_reg, state_next;

  logic                  ap_start_d_reg;
  logic                  cfg_wait_reg;
  logic [LITEWIDTH-1:0]  base_reg;
  logic [W_WIDTH-1:0]    iheight_reg;
  logic [W_WIDTH-1:0]    iwidth_reg;
  logic [DEPTHWIDTH-1:0] ci_reg;
  logic [LB_W-1:0]       line_beats_reg;
  logic [W_WIDTH-1:0]    row_reg;
  logic [CNT_W-1:0]      left_reg;
  logic                  row_done_reg;
  logic                  err_reg;

  logic                  start_edge;
  logic                  idle;
  logic                  cnt_bad;
  logic                  req_early;
  logic                  accept;
  logic                  err_set;
  logic                  is_pad;
  logic [LITEWIDTH-1:0]  row_off;
  logic [LITEWIDTH-1:0]  calc_addr;
  logic                  split_start;
  logic                  split_last;

  // Request qualification and error detection
  always_comb begin
    start_edge = I_ap_start & ~ap_start_d_reg;
    idle       = (state_reg == IDLE);
    cnt_bad    = (I_row_cnt == '0) || (I_row_cnt > CNT_W'(ROWS_PER_REQ));
    req_early  = cfg_wait_reg | start_edge;
    accept     = idle & I_row_req & I_compute_en & ~req_early & ~cnt_bad;
    err_set    = (I_row_req & ~idle)
               | (idle & I_row_req & I_compute_en & (req_early | cnt_bad))
               | (start_edge & ~idle);
  end

  // Row classification and start address of a real row
  always_comb begin
    is_pad    = row_reg[W_WIDTH-1] | (row_reg >= iheight_reg) | (line_beats_reg == '0);
    row_off   = (LITEWIDTH'(row_reg) * LITEWIDTH'(line_beats_reg)) << SHIFT;
    calc_addr = base_reg + row_off;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ap_start_d_reg <= 1'b0;
      cfg_wait_reg   <= 1'b0;
      base_reg       <= '0;
      iheight_reg    <= '0;
      iwidth_reg     <= '0;
      ci_reg         <= '0;
      line_beats_reg <= '0;
    end else begin
      ap_start_d_reg <= I_ap_start;
      cfg_wait_reg   <= start_edge & idle;
      if (start_edge && idle) begin
        base_reg    <= I_feature_base_addr;
        iheight_reg <= I_iheight;
        iwidth_reg  <= I_iwidth;
        ci_reg      <= I_ciMemGroup;
      end
      // Registered one cycle behind the latched config, hence the two-cycle start window
      line_beats_reg <= LB_W'(ci_reg) * LB_W'(iwidth_reg);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      row_reg      <= '0;
      left_reg     <= '0;
      row_done_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (accept) begin
        row_reg  <= I_hindex;
        left_reg <= I_row_cnt;
      end else if (state_reg == NEXT) begin
        row_reg  <= row_reg + 1'b1;
        left_reg <= left_reg - 1'b1;
      end
      row_done_reg <= (state_reg == ISSUE) & split_last;
      if (err_set) begin
        err_reg <= 1'b1;
      end else if (start_edge && idle) begin
        err_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = is_pad ? NEXT : ISSUE;
      ISSUE:   if (split_last) state_next = NEXT;
      NEXT:    state_next = (left_reg == CNT_W'(1)) ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    split_start = (state_reg == CALC) & ~is_pad;
    O_pad_row   = (state_reg == CALC) & is_pad;
    O_row_done  = row_done_reg | ((state_reg == CALC) & is_pad);
    O_req_done  = (state_reg == NEXT) & (left_reg == CNT_W'(1));
    O_req_rdy   = idle & ~req_early;
    O_err       = err_reg;
  end

  dram_burst_splitter #(
    .LITEWIDTH (LITEWIDTH),
    .AXIWIDTH  (AXIWIDTH),
    .BEATS_W   (LB_W),
    .MAX_BURST (MAX_BURST)
  ) u_splitter (
    .clk         (I_clk),
    .rst_n       (I_rst_n),
    .start       (split_start),
    .start_addr  (calc_addr),
    .start_beats (line_beats_reg),
    .rd_valid    (O_rd_valid),
    .rd_addr     (O_rd_addr),
    .rd_len      (O_rd_len),
    .rd_ready    (I_rd_ready),
    .last_hs     (split_last)
  );

endmodule

// File: tb/tb_dram_feature_rd_addr_gen.sv
// Scoreboard bench for dram_feature_rd_addr_gen: directed requests push hand-computed events,
// a negedge monitor pops and compares them. The 4 KB case follows DRAM_FRD_4K_SPLIT_EN.
module tb_dram_feature_rd_addr_gen;

  localparam int W_WIDTH      = 10;
  localparam int LITEWIDTH    = 32;
  localparam int DEPTHWIDTH   = 9;
  localparam int AXIWIDTH     = 128;
  localparam int ROWS_PER_REQ = 3;
  localparam int MAX_BURST    = 16;
  localparam int CNT_W        = $clog2(ROWS_PER_REQ + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ap_start = 1'b0;
  logic                  compute_en = 1'b1;
  logic [LITEWIDTH-1:0]  base = '0;
  logic [DEPTHWIDTH-1:0] ci = '0;
  logic [W_WIDTH-1:0]    ih = '0;
  logic [W_WIDTH-1:0]    iw = '0;
  logic                  row_req = 1'b0;
  logic [W_WIDTH-1:0]    hindex = '0;
  logic [CNT_W-1:0]      row_cnt = '0;
  logic                  req_rdy;
  logic [LITEWIDTH-1:0]  rd_addr;
  logic [7:0]            rd_len;
  logic                  rd_valid;
  logic                  rd_ready = 1'b1;
  logic                  row_done;
  logic                  pad_row;
  logic                  req_done;
  logic                  err;

  always #5 clk = ~clk;

  dram_feature_rd_addr_gen #(
    .W_WIDTH(W_WIDTH), .LITEWIDTH(LITEWIDTH), .DEPTHWIDTH(DEPTHWIDTH),
    .AXIWIDTH(AXIWIDTH), .ROWS_PER_REQ(ROWS_PER_REQ), .MAX_BURST(MAX_BURST)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_ap_start(ap_start), .I_compute_en(compute_en),
    .I_feature_base_addr(base), .I_ciMemGroup(ci), .I_iheight(ih), .I_iwidth(iw),
    .I_row_req(row_req), .I_hindex(hindex), .I_row_cnt(row_cnt),
    .O_req_rdy(req_rdy), .O_rd_addr(rd_addr), .O_rd_len(rd_len), .O_rd_valid(rd_valid),
    .I_rd_ready(rd_ready), .O_row_done(row_done), .O_pad_row(pad_row),
    .O_req_done(req_done), .O_err(err)
  );

  typedef struct packed {
    logic [1:0]  kind;   // 0 burst, 1 row done, 2 request done
    logic [31:0] addr;
    logic [7:0]  len;
    logic        pad;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_rdy = 1'b0;
  bit   stall_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  task automatic push_b(input logic [31:0] a, input logic [7:0] l);
    exp_t e;
    e.kind = 2'd0; e.addr = a; e.len = l; e.pad = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_row(input logic p);
    exp_t e;
    e.kind = 2'd1; e.addr = '0; e.len = '0; e.pad = p;
    exp_q.push_back(e);
  endtask

  task automatic push_req();
    exp_t e;
    e.kind = 2'd2; e.addr = '0; e.len = '0; e.pad = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input logic [1:0] k, input logic [31:0] a, input logic [7:0] l,
                           input logic p);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h len=%0d pad=%0b, required none",
               k, a, l, p);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || (k == 2'd0 && (e.addr !== a || e.len !== l)) ||
          (k == 2'd1 && e.pad !== p)) begin
        fails++;
        $display("FAIL event: got kind=%0d addr=%h len=%0d pad=%0b, required kind=%0d addr=%h len=%0d pad=%0b",
                 k, a, l, p, e.kind, e.addr, e.len, e.pad);
      end else begin
        $display("[TB] event kind=%0d addr=%h len=%0d pad=%0b ok", k, a, l, p);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end else begin
      $display("[TB] check %s = %h ok", name, got);
    end
  endtask

  // Monitor: decoupled from stimulus, pops one expected event per observed output
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (rd_valid !== 1'b1 || rd_addr !== prev_addr || rd_len !== prev_len) begin
          fails++;
          $display("FAIL stall_stable: got valid=%0b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                   rd_valid, rd_addr, rd_len, prev_addr, prev_len);
        end
      end
      if (rd_valid && rd_ready) check_evt(2'd0, rd_addr, rd_len, 1'b0);
      if (row_done) check_evt(2'd1, '0, '0, pad_row);
      if (req_done) check_evt(2'd2, '0, '0, 1'b0);
      stall_prev = rd_valid && !rd_ready;
      prev_addr  = rd_addr;
      prev_len   = rd_len;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 rd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start(input logic [31:0] b, input int c, input int h, input int w);
    @(posedge clk); #1;
    base = b; ci = DEPTHWIDTH'(c); ih = W_WIDTH'(h); iw = W_WIDTH'(w); ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int h, input int cnt, input bit lat);
    @(posedge clk); #1;
    chk("req_rdy_idle", 32'(req_rdy), 32'd1);
    hindex = W_WIDTH'(h); row_cnt = CNT_W'(cnt); row_req = 1'b1;
    @(posedge clk); #1;
    row_req = 1'b0;
    if (lat) begin
      chk("req_rdy_fall_T1", 32'(req_rdy), 32'd0);
      chk("valid_low_T1", 32'(rd_valid), 32'd0);
      @(posedge clk); #1;
      chk("valid_rise_T2", 32'(rd_valid), 32'd1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !req_rdy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || !req_rdy) begin
      fails++;
      $display("FAIL %s_drain: got %0d pending events rdy=%0b, required 0 pending rdy=1",
               name, exp_q.size(), req_rdy);
    end
  endtask

  task automatic push_scn1();
    push_b(32'h1000_0500, 8'd15);
    push_b(32'h1000_0600, 8'd15);
    push_b(32'h1000_0700, 8'd7);
    push_row(1'b0);
    push_req();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_row_done", 32'(row_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_rdy", 32'(req_rdy), 32'd1);

    // 1: single real row split 16/16/8
    do_start(32'h1000_0000, 4, 8, 10);
    push_scn1();
    do_req(2, 1, 1'b1);
    drain("scn1");

    // 2: padding row then two real rows
    push_row(1'b1);
    push_b(32'h1000_0000, 8'd15); push_b(32'h1000_0100, 8'd15); push_b(32'h1000_0200, 8'd7);
    push_row(1'b0);
    push_b(32'h1000_0280, 8'd15); push_b(32'h1000_0380, 8'd15); push_b(32'h1000_0480, 8'd7);
    push_row(1'b0);
    push_req();
    do_req(-1, 3, 1'b0);
    drain("scn2");

    // 3: last real row followed by two bottom padding rows
    push_b(32'h1000_1180, 8'd15); push_b(32'h1000_1280, 8'd15); push_b(32'h1000_1380, 8'd7);
    push_row(1'b0);
    push_row(1'b1);
    push_row(1'b1);
    push_req();
    do_req(7, 3, 1'b0);
    drain("scn3");

    // 4: random back-pressure, same sequence as scenario 1
    rand_rdy = 1'b1;
    push_scn1();
    do_req(2, 1, 1'b0);
    drain("scn4");
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    rd_ready = 1'b1;

    // 5a: request while busy sets the sticky error; next start clears it
    chk("err_before", 32'(err), 32'd0);
    rd_ready = 1'b0;
    push_scn1();
    do_req(2, 1, 1'b0);
    @(posedge clk); #1;
    row_req = 1'b1; hindex = '0; row_cnt = CNT_W'(1);
    @(posedge clk); #1;
    row_req = 1'b0;
    chk("err_busy_req", 32'(err), 32'd1);
    rd_ready = 1'b1;
    drain("scn5a");
    do_start(32'h1000_0000, 4, 8, 10);
    chk("err_cleared", 32'(err), 32'd0);

    // 5b: compute_en low drops silently; row_cnt 0 drops with error
    compute_en = 1'b0;
    do_req(2, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("nocompute_rdy", 32'(req_rdy), 32'd1);
    chk("nocompute_err", 32'(err), 32'd0);
    compute_en = 1'b1;
    do_req(2, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt0_err", 32'(err), 32'd1);
    chk("cnt0_rdy", 32'(req_rdy), 32'd1);

    // 5c: request one cycle after the start edge is too early
    @(posedge clk); #1;
    ap_start = 1'b1;
    @(posedge clk); #1;
    chk("early_rdy", 32'(req_rdy), 32'd0);
    row_req = 1'b1; hindex = W_WIDTH'(2); row_cnt = CNT_W'(1);
    @(posedge clk); #1;
    row_req = 1'b0; ap_start = 1'b0;
    chk("early_cleared_then_set", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("early_dropped_rdy", 32'(req_rdy), 32'd1);
    do_start(32'h1000_0000, 4, 8, 10);
    chk("err_cleared2", 32'(err), 32'd0);

    // 5d: asynchronous reset in the middle of a stalled burst
    rd_ready = 1'b0;
    do_req(2, 1, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(rd_valid), 32'd0);
    chk("async_reset_addr", rd_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_rdy", 32'(req_rdy), 32'd1);
    chk("post_reset_valid", 32'(rd_valid), 32'd0);

    // 6: row crossing a 4 KB page, line_beats = 16
    do_start(32'h0000_0FC0, 1, 4, 16);
`ifdef DRAM_FRD_4K_SPLIT_EN
    push_b(32'h0000_0FC0, 8'd3);
    push_b(32'h0000_1000, 8'd11);
`else
    push_b(32'h0000_0FC0, 8'd15);
`endif
    push_row(1'b0);
    push_req();
    do_req(0, 1, 1'b0);
    drain("scn6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_feature_rd_addr_gen.md
# dram_feature_rd_addr_gen

Parametrised feature-map read address generator feeding the AXI read master. On each row request it turns the window's input-row indices into AXI read bursts: `valid/ready` address plus length pairs, split at `MAX_BURST` beats. Out-of-range (padding) rows are skipped and flagged. It sits between the line-buffer controller, which issues row requests, and the AXI AR channel driver. It replaces the single-address, one-flag-per-row generator.

## Interface
**Parameters**
- `W_WIDTH`, 10: row/column index width; row index is two's complement.
- `LITEWIDTH`, 32: AXI-Lite register and DRAM byte-address width.
- `DEPTHWIDTH`, 9: channel-group count width.
- `AXIWIDTH`, 128: AXI data width in bits; beat bytes are `AXIWIDTH/8`, a power of two.
- `ROWS_PER_REQ`, 3: maximum rows per request (kernel height).
- `MAX_BURST`, 16: maximum beats per burst, in the range 1..256.

**Ports** (clock and reset first)
- `I_clk`, in, 1: the single clock.
- `I_rst_n`, in, 1: reset, asynchronous, active-low.
- `I_ap_start`, in, 1: level signal; its rising edge latches the layer configuration.
- `I_compute_en`, in, 1: row requests are accepted only while this is 1.
- `I_feature_base_addr`, in, `LITEWIDTH`: layer base byte address.
- `I_ciMemGroup`, in, `DEPTHWIDTH`: channel groups, in beats per pixel.
- `I_iheight`, in, `W_WIDTH`: input rows.
- `I_iwidth`, in, `W_WIDTH`: input columns.
- `I_row_req`, in, 1: one-cycle row-request pulse.
- `I_hindex`, in, `W_WIDTH`: signed first row of the request.
- `I_row_cnt`, in, `$clog2(ROWS_PER_REQ+1)`: rows in the request, 1..`ROWS_PER_REQ`.
- `O_req_rdy`, out, 1: the block is idle and a request will be accepted.
- `O_rd_addr`, out, `LITEWIDTH`: burst byte address.
- `O_rd_len`, out, 8: burst length in beats minus 1.
- `O_rd_valid`, out, 1: address/length valid.
- `I_rd_ready`, in, 1: downstream accepts the burst.
- `O_row_done`, out, 1: pulse at the end of each row, real or padding.
- `O_pad_row`, out, 1: qualifies `O_row_done`; 1 means the row was a padding row.
- `O_req_done`, out, 1: pulse when the last row of a request completes.
- `O_err`, out, 1: sticky error flag, cleared by the next `I_ap_start` rising edge.

## Operation
- **Start edge.** On an `I_ap_start` rising edge while idle:
  - latch base, `iheight`, `iwidth` and `ciMemGroup`;
  - compute `line_beats = ciMemGroup*iwidth`, width `DEPTHWIDTH+W_WIDTH`, registered.
- **State machine.**
  - `IDLE`: a request is accepted when `I_row_req && I_compute_en`; latch `row = I_hindex` and `left = I_row_cnt`. Go to `CALC`.
  - `CALC` (one cycle):
    - Padding row: `row` negative (MSB = 1), or `row >= iheight`, or `line_beats == 0`. Pulse `O_row_done` with `O_pad_row = 1` and go to `NEXT`.
    - Otherwise compute `addr = base + ((row*line_beats) << log2(AXIWIDTH/8))`, modulo 2^`LITEWIDTH`; set `rem = line_beats`. Go to `ISSUE`.
  - `ISSUE`:
    - Drive `O_rd_valid` with `len = min(rem, MAX_BURST) - 1`.
    - On handshake, advance `addr` by `(len+1)*beat bytes` and subtract `len+1` from `rem`.
    - When `rem` reaches 0, pulse `O_row_done` (`O_pad_row = 0`) and go to `NEXT`.
  - `NEXT`: `row += 1`, `left -= 1`. If `left == 0`, pulse `O_req_done` and return to `IDLE`; otherwise go to `CALC`.
- **Ignored requests and errors.**
  - `I_row_req` while not idle: the request is dropped and `O_err` is set.
  - `I_row_req` with `I_compute_en = 0`: the request is dropped silently.
  - `I_row_cnt` of 0, or greater than `ROWS_PER_REQ`: the request is dropped and `O_err` is set.
  - `I_ap_start` rising edge while busy: ignored, and `O_err` is set.

## Timing
- **Reset values.** All outputs are 0 in reset except `O_req_rdy`, which is 1 once reset deasserts. Reset asserted mid-burst clears everything asynchronously; no burst is completed.
- **Start to request.** Configuration is usable 2 cycles after the start edge. Requests arriving earlier are dropped and set `O_err`.
- **Request latency.**
  - A request is accepted in cycle T.
  - `O_req_rdy` falls at T+1.
  - `O_rd_valid` first rises at T+2 (`CALC` is at T+1).
- **Valid/ready rules.**
  - Once `O_rd_valid` is high, it and `O_rd_addr`/`O_rd_len` stay stable until `I_rd_ready`.
  - Bursts of a row are back-to-back: `valid` stays high across handshakes with the next pair.
- **Row boundaries.**
  - `O_row_done` for a real row is asserted in the cycle after its last handshake.
  - Each following row adds 2 cycles (`NEXT` then `CALC`) before its first valid.
  - A padding row costs 2 cycles.
- **Request end.** `O_req_done` pulses in `NEXT` of the last row; `O_req_rdy` returns high the following cycle.

## Configuration
- Macro `DRAM_FRD_4K_SPLIT_EN`.
- **Defined:** a burst additionally ends at a 4 KB address boundary. Its length is `min(rem, MAX_BURST, (4096 - addr[11:0]) / beat bytes)`.
- **Undefined:** bursts split only at `MAX_BURST`, and boundary logic is absent.

## Structure
- Shared package `dram_feature_pkg`:
  - state enum (`IDLE`, `CALC`, `ISSUE`, `NEXT`);
  - `BEAT_BYTES` and `BEAT_SHIFT` derivation functions;
  - `AXI_LEN_W = 8`;
  - the 4 KB constant.
- One natural sub-module, `dram_burst_splitter`. It takes a start address and beat count and produces the valid/ready burst sequence, including the 4 KB rule. The parent owns the row iteration, padding and the state machine.

## Test plan
1. Start with base `0x1000_0000`, `ciMemGroup = 4`, `iwidth = 10`, `iheight = 8`; request `hindex = 2`, `cnt = 1`, with `I_rd_ready` held at 1.
   - Required: bursts (`0x1000_0500`, len 15), (`0x1000_0600`, len 15), (`0x1000_0700`, len 7); then `O_row_done`, then `O_req_done`.
2. Same configuration; request `hindex = -1`, `cnt = 3`.
   - Required: row −1 gives `O_pad_row = 1` with no bursts; rows 0 and 1 give 3 bursts each, with addresses starting at base and base+`0x280`.
3. Request `hindex = 7`, `cnt = 3` with `iheight = 8`.
   - Required: row 7 is real; rows 8 and 9 are padding; `O_req_done` pulses once.
4. Back-pressure: `I_rd_ready` toggles randomly during scenario 1.
   - Required: `addr`/`len` are stable while `valid && !ready`; the burst sequence is unchanged.
5. Errors and reset:
   - a second `I_row_req` during `ISSUE` sets `O_err`; the next start edge clears it;
   - `I_rst_n = 0` mid-row clears `O_rd_valid` immediately.
6. With `DRAM_FRD_4K_SPLIT_EN` defined: base `0x0000_0FC0`, `line_beats = 16`, row 0.
   - Required: bursts (`0x0FC0`, len 3), (`0x1000`, len 11).
